// File: rtl/stream_arb2.sv
// Two-input round-robin stream arbiter feeding a single registered output beat.
// The output register refills in the same cycle it drains, so throughput is one beat per cycle.
module stream_arb2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid_i,
  input  logic [WIDTH-1:0] a_data_i,
  output logic             a_ready_o,
  input  logic             b_valid_i,
  input  logic [WIDTH-1:0] b_data_i,
  output logic             b_ready_o,
  output logic             y_valid_o,
  output logic [WIDTH-1:0] y_data_o,
  input  logic             y_ready_i,
  output logic             sel_o
);

  logic             y_valid_q;
  logic             y_valid_d;
  logic [WIDTH-1:0] y_data_q;
  logic [WIDTH-1:0] y_data_d;
  logic             sel_q;
  logic             sel_d;
  logic             prio_a_q;
  logic             prio_a_d;

  logic load_en;
  logic a_wins;
  logic b_wins;
  logic grant_a;
  logic grant_b;

  // a_wins and b_wins are mutually exclusive by construction.
  assign a_wins = a_valid_i && (!b_valid_i || prio_a_q);
  assign b_wins = b_valid_i && (!a_valid_i || !prio_a_q);

  always_comb begin
    load_en = (!y_valid_q || y_ready_i) && !reset;
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (1'b1)
      a_wins:  grant_a = load_en;
      b_wins:  grant_b = load_en;
      default: ;
    endcase
  end

  always_comb begin
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    sel_d     = sel_q;
    prio_a_d  = prio_a_q;
    if (grant_a) begin
      y_valid_d = 1'b1;
      y_data_d  = a_data_i;
      sel_d     = 1'b1;
      prio_a_d  = 1'b0;
    end else if (grant_b) begin
      y_valid_d = 1'b1;
      y_data_d  = b_data_i;
      sel_d     = 1'b0;
      prio_a_d  = 1'b1;
    end else if (load_en) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      sel_q     <= 1'b0;
      prio_a_q  <= 1'b1;
    end else begin
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      sel_q     <= sel_d;
      prio_a_q  <= prio_a_d;
    end
  end

  assign a_ready_o = grant_a;
  assign b_ready_o = grant_b;
  assign y_valid_o = y_valid_q;
  assign y_data_o  = y_data_q;
  assign sel_o     = sel_q;

endmodule

// File: tb/tb_stream_arb2.sv
// Bench for stream_arb2: directed scenarios plus random traffic
// against a behavioural model with per-source queues.
module tb_stream_arb2;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid_i;
  logic [7:0] a_data_i;
  logic       a_ready_o;
  logic       b_valid_i;
  logic [7:0] b_data_i;
  logic       b_ready_o;
  logic       y_valid_o;
  logic [7:0] y_data_o;
  logic       y_ready_i;
  logic       sel_o;

  stream_arb2 #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid_i (a_valid_i),
    .a_data_i  (a_data_i),
    .a_ready_o (a_ready_o),
    .b_valid_i (b_valid_i),
    .b_data_i  (b_data_i),
    .b_ready_o (b_ready_o),
    .y_valid_o (y_valid_o),
    .y_data_o  (y_data_o),
    .y_ready_i (y_ready_i),
    .sel_o     (sel_o)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  // Model: output slot contents, who was served last, beats in flight.
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_sel = 1'b0;
  logic       m_last_a = 1'b0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         armed = 1'b0;

  // {grant_a, grant_b} the rules demand for current inputs.
  function automatic logic [1:0] mgrant();
    if (reset) return 2'b00;
    if (m_valid && !y_ready_i) return 2'b00;
    if (a_valid_i && b_valid_i) return m_last_a ? 2'b01 : 2'b10;
    return {a_valid_i, b_valid_i};
  endfunction

  always @(posedge clk) begin
    logic [1:0] g;
    g = mgrant();
    if (reset) begin
      m_valid = 1'b0;
      m_data = 8'h00;
      m_sel = 1'b0;
      m_last_a = 1'b0;
      qa.delete();
      qb.delete();
      armed = 1'b1;
    end else begin
      if (m_valid && y_ready_i) begin
        if (m_sel && qa.size() > 0) void'(qa.pop_front());
        if (!m_sel && qb.size() > 0) void'(qb.pop_front());
      end
      if (g[1]) begin
        qa.push_back(a_data_i);
        m_valid = 1'b1;
        m_data = a_data_i;
        m_sel = 1'b1;
        m_last_a = 1'b1;
      end else if (g[0]) begin
        qb.push_back(b_data_i);
        m_valid = 1'b1;
        m_data = b_data_i;
        m_sel = 1'b0;
        m_last_a = 1'b0;
      end else if (!m_valid || y_ready_i) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] g;
    if (armed) begin
      g = mgrant();
      chk("y_valid", y_valid_o, m_valid);
      chk("y_data", y_data_o, m_data);
      chk("sel", sel_o, m_sel);
      chk("a_ready", a_ready_o, g[1]);
      chk("b_ready", b_ready_o, g[0]);
      chk("rdy_excl", a_ready_o && b_ready_o, 0);
      if (y_valid_o && y_ready_i && !reset) begin
        if (sel_o) begin
          if (qa.size() == 0) chk("qa_empty", 1, 0);
          else chk("qa_head", y_data_o, qa[0]);
        end else begin
          if (qb.size() == 0) chk("qb_empty", 1, 0);
          else chk("qb_head", y_data_o, qb[0]);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic av, input logic [7:0] ad,
                     input logic bv, input logic [7:0] bd,
                     input logic yr);
    a_valid_i = av;
    a_data_i  = ad;
    b_valid_i = bv;
    b_data_i  = bd;
    y_ready_i = yr;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drv(1, 8'h01, 1, 8'h02, 1);
    chk("rst_a_ready", a_ready_o, 0);
    chk("rst_b_ready", b_ready_o, 0);
    nxt();
    nxt();
    chk("rst_y_valid", y_valid_o, 0);
    chk("rst_y_data", y_data_o, 8'h00);
    chk("rst_sel", sel_o, 0);
    reset = 1'b0;

    drv(1, 8'h3C, 0, 8'h00, 1);
    chk("single_a_ready", a_ready_o, 1);
    chk("single_b_ready", b_ready_o, 0);
    nxt();
    drv(0, 8'h00, 0, 8'h00, 1);
    chk("single_y_valid", y_valid_o, 1);
    chk("single_y_data", y_data_o, 8'h3C);
    chk("single_sel", sel_o, 1);

    reset = 1'b1;
    nxt();
    reset = 1'b0;
    drv(1, 8'hAA, 1, 8'h55, 1);
    chk("cont_first_a", a_ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("cont_valid", y_valid_o, 1);
      chk("cont_data", y_data_o, (i % 2 == 0) ? 8'hAA : 8'h55);
      chk("cont_sel", sel_o, (i % 2 == 0) ? 1 : 0);
    end

    drv(1, 8'hAA, 1, 8'h55, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_a_ready", a_ready_o, 0);
      chk("bp_b_ready", b_ready_o, 0);
      nxt();
      chk("bp_data", y_data_o, 8'h55);
      chk("bp_sel", sel_o, 0);
      chk("bp_valid", y_valid_o, 1);
    end
    drv(1, 8'hAA, 1, 8'h55, 1);
    chk("bp_release_a", a_ready_o, 1);
    nxt();
    chk("bp_new_data", y_data_o, 8'hAA);
    chk("bp_new_sel", sel_o, 1);

    drv(0, 8'h00, 1, 8'h12, 1);
    chk("drain_b_ready", b_ready_o, 1);
    nxt();
    drv(0, 8'h00, 0, 8'h00, 1);
    chk("drain_valid", y_valid_o, 1);
    chk("drain_data", y_data_o, 8'h12);
    chk("drain_sel", sel_o, 0);
    nxt();
    chk("drain_gone", y_valid_o, 0);
    chk("drain_hold", y_data_o, 8'h12);
    chk("drain_sel_hold", sel_o, 0);

    drv(1, 8'h77, 0, 8'h00, 0);
    nxt();
    chk("mid_valid", y_valid_o, 1);
    reset = 1'b1;
    drv(1, 8'h11, 1, 8'h22, 1);
    chk("mid_rst_a_ready", a_ready_o, 0);
    chk("mid_rst_b_ready", b_ready_o, 0);
    nxt();
    reset = 1'b0;
    drv(1, 8'h11, 1, 8'h22, 1);
    chk("mid_y_valid", y_valid_o, 0);
    chk("mid_y_data", y_data_o, 8'h00);
    chk("mid_a_first", a_ready_o, 1);
    nxt();
    chk("mid_grant_data", y_data_o, 8'h11);
    chk("mid_grant_sel", sel_o, 1);

    for (int i = 0; i < 1000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      drv($urandom_range(0, 2) != 0, 8'($urandom),
          $urandom_range(0, 2) != 0, 8'($urandom),
          $urandom_range(0, 3) != 0);
      nxt();
    end
    reset = 1'b0;
    drv(0, 8'h00, 0, 8'h00, 1);
    nxt();
    nxt();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
